axi4_rw_addr_sched: RTL and testbench

Address-channel scheduler that shares one AXI4 memory port between a write requester and a read requester, typically the write and read halves of a burst-partition stage. It picks which request (AW or AR) issues next using weighted round-robin, caps outstanding transactions per direction, and registers the selected address onto a single tagged output channel. Data channels bypass this block; only per-transaction completion pulses are fed back.

---
 rtl/axi4_rw_addr_sched_if.sv | 38 +++
 rtl/axi4_rw_addr_sched.sv | 148 ++++++++++++++
 tb/tb_axi4_rw_addr_sched.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_rw_addr_sched_if.sv
// Bundle of the request, scheduled-address, completion and counter signals
// of axi4_rw_addr_sched. slave = scheduler view, master = surrounding logic.
interface axi4_rw_addr_sched_if #(
    parameter int ASIZE = 32,
    parameter int LSIZE = 8
);
    logic             wr_valid;
    logic             wr_ready;
    logic [ASIZE-1:0] wr_addr;
    logic [LSIZE-1:0] wr_len;
    logic             rd_valid;
    logic             rd_ready;
    logic [ASIZE-1:0] rd_addr;
    logic [LSIZE-1:0] rd_len;
    logic             out_valid;
    logic             out_ready;
    logic [ASIZE-1:0] out_addr;
    logic [LSIZE-1:0] out_len;
    logic             out_write;
    logic             wr_done;
    logic             rd_done;
    logic [7:0]       wr_cnt;
    logic [7:0]       rd_cnt;

    modport slave (
        input  wr_valid, wr_addr, wr_len, rd_valid, rd_addr, rd_len,
        input  out_ready, wr_done, rd_done,
        output wr_ready, rd_ready, out_valid, out_addr, out_len, out_write,
        output wr_cnt, rd_cnt
    );

    modport master (
        output wr_valid, wr_addr, wr_len, rd_valid, rd_addr, rd_len,
        output out_ready, wr_done, rd_done,
        input  wr_ready, rd_ready, out_valid, out_addr, out_len, out_write,
        input  wr_cnt, rd_cnt
    );
endinterface

// File: rtl/axi4_rw_addr_sched.sv
// Weighted round-robin AW/AR scheduler onto one registered, tagged address channel.
// Optional read-after-write page blocking is enabled by defining AXI4_SCHED_RAW_CHECK_EN.
module axi4_rw_addr_sched #(
    parameter int ASIZE           = 32,
    parameter int LSIZE           = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int WR_WEIGHT       = 4,
    parameter int RD_WEIGHT       = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    axi4_rw_addr_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    localparam logic [8:0] MAX_OUT = 9'(MAX_OUTSTANDING);
    localparam logic [7:0] WR_W    = 8'(WR_WEIGHT);
    localparam logic [7:0] RD_W    = 8'(RD_WEIGHT);

    state_t           state, state_nxt;
    logic [7:0]       streak, streak_nxt;
    logic [7:0]       wr_cnt_q, rd_cnt_q;
    logic             out_valid_q, out_write_q;
    logic [ASIZE-1:0] out_addr_q;
    logic [LSIZE-1:0] out_len_q;
    logic             load, wr_grant, rd_grant;
    logic             wr_elig, rd_elig, raw_block;
    logic [8:0]       wr_inflight, rd_inflight;
    logic             wr_inc, wr_dec, rd_inc, rd_dec;

    assign load = !out_valid_q || bus.out_ready;

    // The entry parked in the output register is not yet counted, so it is added here
    // to keep the per-direction total at MAX_OUTSTANDING.
    assign wr_inflight = {1'b0, wr_cnt_q} + {8'd0, out_valid_q &&  out_write_q};
    assign rd_inflight = {1'b0, rd_cnt_q} + {8'd0, out_valid_q && !out_write_q};

    assign wr_elig = bus.wr_valid && (wr_inflight < MAX_OUT);
    assign rd_elig = bus.rd_valid && (rd_inflight < MAX_OUT) && !raw_block;

`ifdef AXI4_SCHED_RAW_CHECK_EN
    logic [ASIZE-13:0] wr_page_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_page_q <= '0;
        end else if (out_valid_q && bus.out_ready && out_write_q) begin
            wr_page_q <= out_addr_q[ASIZE-1:12];
        end
    end

    assign raw_block = (wr_cnt_q != 8'd0) && (bus.rd_addr[ASIZE-1:12] == wr_page_q);
`else
    assign raw_block = 1'b0;
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    // A cycle that changes state never grants; the new direction is served next cycle.
    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        wr_grant   = 1'b0;
        rd_grant   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_elig)      state_nxt = WR;
                else if (rd_elig) state_nxt = RD;
            end
            WR: begin
                if (rd_elig && (streak == WR_W || !wr_elig)) begin
                    state_nxt = RD;
                end else if (!wr_elig && !rd_elig) begin
                    state_nxt = IDLE;
                end else begin
                    wr_grant = load;
                    if (load && streak != WR_W) streak_nxt = streak + 8'd1;
                end
            end
            RD: begin
                if (wr_elig && (streak == RD_W || !rd_elig)) begin
                    state_nxt = WR;
                end else if (!wr_elig && !rd_elig) begin
                    state_nxt = IDLE;
                end else begin
                    rd_grant = load;
                    if (load && streak != RD_W) streak_nxt = streak + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) streak_nxt = '0;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_write_q <= 1'b0;
            out_addr_q  <= '0;
            out_len_q   <= '0;
        end else if (load) begin
            out_valid_q <= wr_grant || rd_grant;
            if (wr_grant) begin
                out_write_q <= 1'b1;
                out_addr_q  <= bus.wr_addr;
                out_len_q   <= bus.wr_len;
            end else if (rd_grant) begin
                out_write_q <= 1'b0;
                out_addr_q  <= bus.rd_addr;
                out_len_q   <= bus.rd_len;
            end
        end
    end

    assign wr_inc = out_valid_q && bus.out_ready &&  out_write_q;
    assign rd_inc = out_valid_q && bus.out_ready && !out_write_q;
    assign wr_dec = bus.wr_done && (wr_cnt_q != 8'd0);
    assign rd_dec = bus.rd_done && (rd_cnt_q != 8'd0);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (wr_inc && !wr_dec && wr_cnt_q != 8'hFF) wr_cnt_q <= wr_cnt_q + 8'd1;
            else if (wr_dec && !wr_inc)                 wr_cnt_q <= wr_cnt_q - 8'd1;
            if (rd_inc && !rd_dec && rd_cnt_q != 8'hFF) rd_cnt_q <= rd_cnt_q + 8'd1;
            else if (rd_dec && !rd_inc)                 rd_cnt_q <= rd_cnt_q - 8'd1;
        end
    end

    assign bus.wr_ready  = wr_grant;
    assign bus.rd_ready  = rd_grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_write = out_write_q;
    assign bus.wr_cnt    = wr_cnt_q;
    assign bus.rd_cnt    = rd_cnt_q;
endmodule

// File: tb/tb_axi4_rw_addr_sched.sv
// Scoreboard bench for axi4_rw_addr_sched: accepted requests queue their expected
// output; a negedge monitor checks every presented address and the outstanding counts.
module tb_axi4_rw_addr_sched;
    localparam int ASIZE = 32;
    localparam int LSIZE = 8;
`ifdef AXI4_SCHED_RAW_CHECK_EN
    localparam int RAW_SAME_PAGE_EXP = 0;
`else
    localparam int RAW_SAME_PAGE_EXP = 1;
`endif

    typedef logic [ASIZE+LSIZE:0] item_t;   // {write, len, addr}

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    axi4_rw_addr_sched_if #(.ASIZE(ASIZE), .LSIZE(LSIZE)) bus ();

    axi4_rw_addr_sched #(
        .ASIZE(ASIZE), .LSIZE(LSIZE), .MAX_OUTSTANDING(8), .WR_WEIGHT(4), .RD_WEIGHT(4)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    int     checks = 0;
    int     passed = 0;
    item_t  exp_q[$];
    int     m_wr = 0, m_rd = 0;
    int     wr_acc = 0, rd_acc = 0;
    bit     wr_fire = 0, rd_fire = 0;
    bit     rec_en = 0, rec_started = 0;
    logic [1:0] rec_q[$];
    bit     force_len15 = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Outstanding = issued minus completed, never below zero, capped at 255.
    function automatic int outstanding(input int c, input bit issued, input bit done);
        int d;
        d = (issued ? 1 : 0) - ((done && c != 0) ? 1 : 0);
        c = c + d;
        if (c > 255) c = 255;
        return c;
    endfunction

    always @(negedge clock) begin
        if (rst) begin
            exp_q.delete();
            m_wr = 0; m_rd = 0;
            wr_fire = 0; rd_fire = 0;
        end else begin
            check("both_ready", bus.wr_ready & bus.rd_ready, 0);
            check("wr_cnt", bus.wr_cnt, m_wr);
            check("rd_cnt", bus.rd_cnt, m_rd);
            if (bus.out_valid) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_payload", item_t'({bus.out_write, bus.out_len, bus.out_addr}), exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (!rec_en) rec_started = 0;
            else begin
                if (bus.out_valid && bus.out_ready) rec_started = 1;
                if (rec_started)
                    rec_q.push_back((bus.out_valid && bus.out_ready) ? {1'b1, bus.out_write} : 2'b00);
            end
            m_wr = outstanding(m_wr, bus.out_valid && bus.out_ready &&  bus.out_write, bus.wr_done);
            m_rd = outstanding(m_rd, bus.out_valid && bus.out_ready && !bus.out_write, bus.rd_done);
            wr_fire = bus.wr_valid && bus.wr_ready;
            rd_fire = bus.rd_valid && bus.rd_ready;
            if (wr_fire) begin
                exp_q.push_back({1'b1, bus.wr_len, bus.wr_addr});
                wr_acc++;
            end
            if (rd_fire) begin
                exp_q.push_back({1'b0, bus.rd_len, bus.rd_addr});
                rd_acc++;
            end
        end
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic zero_inputs();
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_len = '0;
        bus.rd_valid = 0; bus.rd_addr = '0; bus.rd_len = '0;
        bus.out_ready = 0; bus.wr_done = 0; bus.rd_done = 0;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1;
        zero_inputs();
        repeat (2) cyc();
        rst = 0;
    endtask

    // Requests stay stable until accepted; new random ones appear afterwards.
    task automatic step(input int wp, input int rp, input int op, input int dp);
        cyc();
        if (!bus.wr_valid || wr_fire) begin
            bus.wr_valid = ($urandom_range(99) < wp);
            bus.wr_addr  = $urandom;
            bus.wr_len   = force_len15 ? LSIZE'(15) : LSIZE'($urandom);
        end
        if (!bus.rd_valid || rd_fire) begin
            bus.rd_valid = ($urandom_range(99) < rp);
            bus.rd_addr  = $urandom;
            bus.rd_len   = LSIZE'($urandom);
        end
        bus.out_ready = ($urandom_range(99) < op);
        bus.wr_done   = ($urandom_range(99) < dp);
        bus.rd_done   = ($urandom_range(99) < dp);
    endtask

    task automatic drain();
        int n = 0;
        while (n < 300 && (bus.wr_valid || bus.rd_valid || exp_q.size() != 0)) begin
            step(0, 0, 100, 50);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_addr"},  bus.out_addr, 0);
        check({tag, "_out_len"},   bus.out_len, 0);
        check({tag, "_out_write"}, bus.out_write, 0);
        check({tag, "_wr_ready"},  bus.wr_ready, 0);
        check({tag, "_rd_ready"},  bus.rd_ready, 0);
        check({tag, "_wr_cnt"},    bus.wr_cnt, 0);
        check({tag, "_rd_cnt"},    bus.rd_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n, base, rbase;
        int pos;
        logic [1:0] e;
        zero_inputs();

        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check_reset_outs("reset");

        // Writes only, len 15, no completions: the outstanding cap stops at 8.
        do_reset();
        force_len15 = 1;
        base = wr_acc;
        repeat (20) step(100, 0, 100, 0);
        @(negedge clock); #1;
        check("limit_accepts", wr_acc - base, 8);
        check("limit_wr_cnt", bus.wr_cnt, 8);
        check("limit_wr_ready", bus.wr_ready, 0);
        step(100, 0, 100, 100);
        repeat (6) step(100, 0, 100, 0);
        @(negedge clock); #1;
        check("limit_reenable", wr_acc - base, 9);
        check("limit_wr_cnt_after", bus.wr_cnt, 8);
        force_len15 = 0;

        // Both directions saturated: 4 writes, bubble, 4 reads, bubble, repeating.
        do_reset();
        rec_en = 1;
        repeat (45) step(100, 100, 100, 100);
        rec_en = 0;
        check("wrr_len", rec_q.size() >= 30, 1);
        for (int i = 0; i < 30 && i < rec_q.size(); i++) begin
            pos = i % 10;
            if (pos == 4 || pos == 9) e = 2'b00;
            else                      e = {1'b1, (pos < 4) ? 1'b1 : 1'b0};
            check($sformatf("wrr_slot%0d", i), rec_q[i], e);
        end

        // Reads only with a stalling output channel.
        do_reset();
        base = rd_acc;
        repeat (150) step(0, 70, 50, 30);
        drain();
        check("reads_flowed", (rd_acc - base) > 20, 1);

        // Issue and completion in the same cycle leave the count unchanged.
        do_reset();
        base = wr_acc;
        bus.out_ready = 1;
        bus.wr_valid = 1;
        bus.wr_addr = $urandom;
        for (n = 0; n < 20; n++) begin
            cyc();
            if (wr_acc - base >= 3) break;
            if (wr_fire) bus.wr_addr = $urandom;
        end
        bus.wr_valid = 0;
        repeat (3) cyc();
        check("simul_pre_cnt", bus.wr_cnt, 3);
        bus.out_ready = 0;
        bus.wr_valid = 1;
        bus.wr_addr = $urandom;
        for (n = 0; n < 10; n++) begin
            cyc();
            if (wr_acc - base >= 4) break;
        end
        bus.wr_valid = 0;
        check("simul_out_valid", bus.out_valid, 1);
        bus.out_ready = 1;
        bus.wr_done = 1;
        cyc();
        bus.wr_done = 0;
        @(negedge clock); #1;
        check("simul_cnt", bus.wr_cnt, 3);
        cyc();
        bus.wr_done = 1;
        repeat (3) cyc();
        bus.wr_done = 0;
        cyc();
        check("drained_cnt", bus.wr_cnt, 0);
        bus.wr_done = 1;
        cyc();
        bus.wr_done = 0;
        cyc();
        check("underflow_cnt", bus.wr_cnt, 0);

        // Read-after-write page check.
        do_reset();
        base = wr_acc;
        bus.out_ready = 1;
        bus.wr_addr = 32'h0000_1000;
        bus.wr_len = '0;
        bus.wr_valid = 1;
        for (n = 0; n < 10 && wr_acc == base; n++) cyc();
        bus.wr_valid = 0;
        repeat (2) cyc();
        check("raw_wr_cnt", bus.wr_cnt, 1);
        rbase = rd_acc;
        bus.rd_addr = 32'h0000_2000;
        bus.rd_len = LSIZE'(3);
        bus.rd_valid = 1;
        for (n = 0; n < 4 && rd_acc == rbase; n++) cyc();
        bus.rd_valid = 0;
        check("raw_other_page", rd_acc - rbase, 1);
        repeat (2) cyc();
        rbase = rd_acc;
        bus.rd_addr = 32'h0000_1800;
        bus.rd_valid = 1;
        repeat (6) begin
            cyc();
            if (rd_acc != rbase) bus.rd_valid = 0;
        end
        check("raw_same_page", rd_acc - rbase, RAW_SAME_PAGE_EXP);
        bus.wr_done = 1;
        cyc();
        bus.wr_done = 0;
        repeat (5) begin
            cyc();
            if (rd_acc != rbase) bus.rd_valid = 0;
        end
        bus.rd_valid = 0;
        check("raw_release", rd_acc - rbase, 1);

        // Asynchronous reset with traffic in flight.
        do_reset();
        bus.out_ready = 1;
        bus.wr_valid = 1;
        bus.wr_addr = $urandom;
        for (n = 0; n < 30; n++) begin
            @(negedge clock); #1;
            if (bus.wr_cnt == 8'd5 && bus.out_valid) break;
        end
        check("midrst_setup", bus.wr_cnt, 5);
        #1 rst = 1;
        #1;
        check_reset_outs("midrst");
        zero_inputs();
        repeat (2) cyc();
        rst = 0;

        // Mixed random traffic after reset release.
        base = wr_acc;
        rbase = rd_acc;
        repeat (300) step(60, 60, 70, 25);
        drain();
        check("mixed_writes", (wr_acc - base) > 10, 1);
        check("mixed_reads", (rd_acc - rbase) > 10, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
